// File: rtl/cla_serial_subtractor_if.sv
// Valid/ready operand and result channels for the nibble-serial CLA subtractor.
// The master modport is the operand source and result consumer; the slave modport is the subtractor.
interface cla_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid,
    output a,
    output b,
    output bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  bout,
    input  zero,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output bout,
    output zero,
    output ovf
  );
endinterface

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit carry-lookahead nibble per clock,
// computed as a + ~b + ~bin, with valid/ready handshakes on the operand and result sides.
module cla_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  cla_serial_subtractor_if.slave bus
);

  localparam int NIBS = WIDTH / 4;
  localparam int IDXW = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   idx_reg, idx_next;
  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  nb_reg, nb_next;
  logic              carry_reg, carry_next;
  logic [WIDTH-1:0]  diff_reg, diff_next;
  logic              bout_reg, bout_next;
  logic              zero_reg, zero_next;
  logic              ovf_reg, ovf_next;

  logic [3:0]        a_nibs  [NIBS];
  logic [3:0]        nb_nibs [NIBS];
  logic [3:0]        a_nib;
  logic [3:0]        nb_nib;
  logic [3:0]        g;
  logic [3:0]        p;
  logic [4:0]        c;
  logic [3:0]        sum;
  logic              calc_active;
  logic              last_nib;

  // Split the held operands into nibbles so the active one is a plain array select.
  generate
    for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib_split
      assign a_nibs[gi]  = a_reg[4*gi +: 4];
      assign nb_nibs[gi] = nb_reg[4*gi +: 4];
    end
  endgenerate

  assign a_nib  = a_nibs[idx_reg];
  assign nb_nib = nb_nibs[idx_reg];

  assign g = a_nib & nb_nib;
  assign p = a_nib ^ nb_nib;

  // Flattened lookahead: every carry depends only on g, p and the incoming carry.
  assign c[0] = carry_reg;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum = p ^ c[3:0];

  assign calc_active = (state_reg == CALC);
  assign last_nib    = calc_active && (idx_reg == LAST_IDX);

  // Only the nibble selected by idx is rewritten; the rest of diff holds.
  generate
    for (genvar gi = 0; gi < NIBS; gi++) begin : g_diff_merge
      localparam logic [IDXW-1:0] NIB_IDX = IDXW'(gi);
      assign diff_next[4*gi +: 4] = (calc_active && (idx_reg == NIB_IDX))
                                  ? sum : diff_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    a_next     = a_reg;
    nb_next    = nb_reg;
    carry_next = carry_reg;
    bout_next  = bout_reg;
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
          nb_next    = ~bus.b;
          carry_next = ~bus.bin;
          idx_next   = '0;
          state_next = CALC;
        end
      end

      CALC: begin
        carry_next = c[4];
        idx_next   = idx_reg + 1'b1;
        if (last_nib) begin
          idx_next   = '0;
          state_next = DONE;
          bout_next  = ~c[4];
          zero_next  = (diff_next == '0);
          // b's sign is recovered from the stored complement.
          ovf_next   = (a_reg[MSB] != ~nb_reg[MSB]) && (diff_next[MSB] != a_reg[MSB]);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      diff_reg  <= diff_next;
      bout_reg  <= bout_next;
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Operand and carry holding registers are only meaningful after an accept.
  always_ff @(posedge clk) begin
    a_reg     <= a_next;
    nb_reg    <= nb_next;
    carry_reg <= carry_next;
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.zero      = zero_reg;
  assign bus.ovf       = ovf_reg;

endmodule
